// File: rtl/match_reporter_if.sv
// Report-beat stream between match_reporter and its downstream consumer.
// valid/ready handshake; id/hit/last stay stable while valid is held without ready.
interface match_reporter_if #(
    parameter int unsigned ID_W = 5
) ();
    logic            m_valid;
    logic            m_ready;
    logic [ID_W-1:0] m_id;
    logic            m_hit;
    logic            m_last;

    modport master (
        output m_valid,
        output m_id,
        output m_hit,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_id,
        input  m_hit,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/match_reporter.sv
// Captures the sticky engine match vector once per packet (on eod) and streams one beat per
// matching engine, lowest index first, or a single "no match" beat when nothing matched.
module match_reporter #(
    parameter int unsigned NUM_ENG = 32,
    parameter int unsigned ID_W    = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_sod,
    input  logic               i_eod,
    input  logic [NUM_ENG-1:0] i_match_in,
    match_reporter_if.master   m_if,
    output logic               o_busy,
    output logic [15:0]        o_drop_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StScan
    } state_e;

    localparam logic [NUM_ENG-1:0] PEND_ONE = NUM_ENG'(1);

    state_e             r_state;
    state_e             w_state_d;
    logic [NUM_ENG-1:0] r_pend;
    logic [NUM_ENG-1:0] w_pend_d;
    logic [15:0]        r_drop_cnt;
    logic [15:0]        w_drop_cnt_d;
    logic               r_busy;

    logic               w_scan;
    logic               w_hs;
    logic               w_last_beat;
    logic               w_drop;
    logic [ID_W-1:0]    w_low_id;

    // The captured vector no longer depends on the engines, so sod is deliberately ignored.
    logic               w_unused_sod;
    assign w_unused_sod = i_sod;

    // Lowest set index of the pending vector; indices beyond NUM_ENG-1 cannot be produced.
    always_comb begin
        w_low_id = '0;
        for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_id = ID_W'(i);
            end
        end
    end

    assign w_scan      = (r_state == StScan);
    assign w_hs        = w_scan && m_if.m_ready;
    // Zero or one bit left: covers both the final hit beat and the lone "no match" beat.
    assign w_last_beat = ((r_pend & (r_pend - PEND_ONE)) == '0);

    assign m_if.m_valid = w_scan;
    assign m_if.m_hit   = w_scan && (|r_pend);
    assign m_if.m_last  = w_scan && w_last_beat;
    assign m_if.m_id    = w_scan ? w_low_id : '0;

    always_comb begin
        w_state_d = r_state;
        w_pend_d  = r_pend;
        w_drop    = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_eod) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                w_pend_d  = i_match_in;
                w_state_d = StScan;
                w_drop    = i_eod;
            end
            StScan: begin
                if (w_hs) begin
                    w_pend_d = r_pend & (r_pend - PEND_ONE);
                end
                // eod landing on the final handshake starts the next report instead of dropping.
                if (w_hs && w_last_beat) begin
                    w_state_d = i_eod ? StWait : StIdle;
                end else if (i_eod) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_drop_cnt_d = (w_drop && (r_drop_cnt != 16'hFFFF)) ? r_drop_cnt + 16'd1 : r_drop_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StIdle;
            r_pend     <= '0;
            r_drop_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pend     <= w_pend_d;
            r_drop_cnt <= w_drop_cnt_d;
            r_busy     <= (w_state_d != StIdle);
        end
    end

    assign o_busy     = r_busy;
    assign o_drop_cnt = r_drop_cnt;

endmodule
